// File: rtl/mfhwt_pkg.sv
// Shared constants and FSM state encodings for the ping-pong line buffer sequencer.
package mfhwt_pkg;

  localparam int WIDTH = 640;
  localparam int ROWS  = 4;

  typedef enum logic {
    WR_FILL = 1'b0,
    WR_WAIT = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } rd_state_t;

endpackage

// File: rtl/mfhwt_ppbuf_rdseq.sv
// Read sequencer: drains one bank as a WIDTH-word burst, paced by downstream ready.
module mfhwt_ppbuf_rdseq #(
  parameter int WIDTH = mfhwt_pkg::WIDTH,
  parameter int CW    = 10
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iStart,
  input  logic iOutReady,
  output logic oRdFire,
  output logic oRdIdle,
  output logic oValid,
  output logic oBankDone
);
  import mfhwt_pkg::*;

  rd_state_t     r_state, w_stateNext;
  logic [CW-1:0] r_rdcnt, w_rdcntNext;
  logic          r_valid, r_bankDone;
  logic          w_fire, w_last;

  assign oRdFire   = w_fire;
  assign oRdIdle   = (r_state == RD_IDLE);
  assign oValid    = r_valid;
  assign oBankDone = r_bankDone;

  always_comb begin
    w_stateNext = r_state;
    w_rdcntNext = r_rdcnt;
    w_fire      = (r_state == RD_BURST) & iOutReady;
    w_last      = (r_rdcnt == CW'(WIDTH - 1));
    case (r_state)
      RD_IDLE: begin
        if (iStart) begin
          w_stateNext = RD_BURST;
          w_rdcntNext = '0;
        end
      end
      RD_BURST: begin
        if (w_fire) begin
          if (w_last) begin
            w_stateNext = RD_IDLE;
            w_rdcntNext = '0;
          end else begin
            w_rdcntNext = r_rdcnt + 1'b1;
          end
        end
      end
      default: w_stateNext = RD_IDLE;
    endcase
  end

  // oValid trails the read request by the buffer's one-cycle read latency.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_state    <= RD_IDLE;
      r_rdcnt    <= '0;
      r_valid    <= 1'b0;
      r_bankDone <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_rdcnt    <= w_rdcntNext;
      r_valid    <= w_fire;
      r_bankDone <= w_fire & w_last;
    end
  end

endmodule

// File: rtl/mfhwt_ppbuf_ctrl.sv
// Ping-pong line buffer sequencer: fills one bank row by row, swaps, drains the other.
// Optional sticky error checking is enabled by defining MFHWT_PPBUF_CTRL_CHK_EN.
module mfhwt_ppbuf_ctrl #(
  parameter int WIDTH = mfhwt_pkg::WIDTH,
  parameter int ROWS  = mfhwt_pkg::ROWS,
  parameter int CW    = 10
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iValid,
  input  logic [15:0] iData,
  output logic        oReady,
  output logic [15:0] oBufData,
  output logic [7:0]  oBufWrreq,
  output logic        oBufSelect,
  output logic [1:0]  oBufRdreq,
  input  logic [7:0]  iBufFull,
  input  logic [1:0]  iBufEmpty,
  input  logic        iOutReady,
  output logic        oValid,
  output logic        oBankDone,
  output logic        oErr
);
  import mfhwt_pkg::*;

  wr_state_t     r_wrState, w_wrStateNext;
  logic [CW-1:0] r_col, w_colNext;
  logic [1:0]    r_row, w_rowNext;
  logic          r_sel, w_selNext;
  logic [15:0]   r_bufData;
  logic [7:0]    r_bufWrreq;
  logic          w_accept, w_swap, w_rdIdle, w_rdFire;

  // Ready is held low while in reset so nothing is taken during that cycle.
  assign oReady     = iRst_n & (r_wrState == WR_FILL);
  assign w_accept   = iValid & oReady;
  assign w_swap     = (r_wrState == WR_WAIT) & w_rdIdle;
  assign oBufData   = r_bufData;
  assign oBufWrreq  = r_bufWrreq;
  assign oBufSelect = r_sel;
  assign oBufRdreq  = (iRst_n & w_rdFire) ? (r_sel ? 2'b01 : 2'b10) : 2'b00;

  always_comb begin
    w_wrStateNext = r_wrState;
    w_colNext     = r_col;
    w_rowNext     = r_row;
    w_selNext     = r_sel;
    case (r_wrState)
      WR_FILL: begin
        if (w_accept) begin
          if (r_col == CW'(WIDTH - 1)) begin
            w_colNext = '0;
            if (r_row == 2'(ROWS - 1)) begin
              w_rowNext     = '0;
              w_wrStateNext = WR_WAIT;
            end else begin
              w_rowNext = r_row + 1'b1;
            end
          end else begin
            w_colNext = r_col + 1'b1;
          end
        end
      end
      WR_WAIT: begin
        if (w_swap) begin
          w_wrStateNext = WR_FILL;
          w_colNext     = '0;
          w_rowNext     = '0;
          w_selNext     = ~r_sel;
        end
      end
      default: w_wrStateNext = WR_FILL;
    endcase
  end

  // Write side registers; the write request is a one-cycle pulse per accepted pixel.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_wrState  <= WR_FILL;
      r_col      <= '0;
      r_row      <= '0;
      r_sel      <= 1'b0;
      r_bufData  <= '0;
      r_bufWrreq <= '0;
    end else begin
      r_wrState  <= w_wrStateNext;
      r_col      <= w_colNext;
      r_row      <= w_rowNext;
      r_sel      <= w_selNext;
      r_bufWrreq <= w_accept ? (8'd1 << {r_sel, r_row}) : 8'd0;
      if (w_accept) begin
        r_bufData <= iData;
      end
    end
  end

  mfhwt_ppbuf_rdseq #(
    .WIDTH(WIDTH),
    .CW   (CW)
  ) u_rdseq (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iStart   (w_swap),
    .iOutReady(iOutReady),
    .oRdFire  (w_rdFire),
    .oRdIdle  (w_rdIdle),
    .oValid   (oValid),
    .oBankDone(oBankDone)
  );

`ifdef MFHWT_PPBUF_CTRL_CHK_EN
  logic       r_err;
  logic [3:0] w_wrBankFull;
  logic       w_errHit;

  // A swap away from a bank that is not completely full is flagged but still taken.
  always_comb begin
    w_wrBankFull = r_sel ? iBufFull[7:4] : iBufFull[3:0];
    w_errHit     = (|(r_bufWrreq & iBufFull)) | (|(oBufRdreq & iBufEmpty)) |
                   (w_swap & (w_wrBankFull != 4'hF));
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_err <= 1'b0;
    end else if (w_errHit) begin
      r_err <= 1'b1;
    end
  end

  assign oErr = r_err;
`else
  logic w_unused;
  assign w_unused = ^{iBufFull, iBufEmpty};
  assign oErr     = 1'b0;
`endif

endmodule

// File: tb/tb_mfhwt_ppbuf_ctrl.sv
// Randomized bench for mfhwt_ppbuf_ctrl against a pixel/word counting reference model.
module tb_mfhwt_ppbuf_ctrl;

  localparam int W    = 640;
  localparam int BANK = 4 * W;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [15:0] data;
  logic        ready;
  logic [15:0] bufData;
  logic [7:0]  bufWrreq;
  logic        bufSelect;
  logic [1:0]  bufRdreq;
  logic [7:0]  bufFull;
  logic [1:0]  bufEmpty;
  logic        outReady;
  logic        oValid;
  logic        bankDone;
  logic        err;

  int checks = 0;
  int errors = 0;

  // Reference model: pixels in the bank being filled, words left in the burst.
  int          mFill   = 0;
  int          mRdLeft = 0;
  bit          mWait   = 0;
  bit          mSel    = 0;
  logic [7:0]  eWrreq  = '0;
  logic [15:0] eData   = '0;
  bit          eValid  = 0;
  bit          eDone   = 0;
  bit          eErr    = 0;

  mfhwt_ppbuf_ctrl dut (
    .iClk      (clk),
    .iRst_n    (rst_n),
    .iValid    (valid),
    .iData     (data),
    .oReady    (ready),
    .oBufData  (bufData),
    .oBufWrreq (bufWrreq),
    .oBufSelect(bufSelect),
    .oBufRdreq (bufRdreq),
    .iBufFull  (bufFull),
    .iBufEmpty (bufEmpty),
    .iOutReady (outReady),
    .oValid    (oValid),
    .oBankDone (bankDone),
    .oErr      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      if (errors <= 40)
        $display("[TB] FAIL %s at %0t: observed %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  // One cycle: drive inputs after the falling edge, compare, then advance the model.
  task automatic applyStimulus(input bit r, input bit v, input bit o,
                               input logic [7:0] full, input logic [1:0] empty);
    bit         accept, fire, swap;
    logic [1:0] eRdreq;
    @(negedge clk);
    rst_n    = r;
    valid    = v;
    outReady = o;
    bufFull  = full;
    bufEmpty = empty;
    data     = 16'($urandom);
    #1;
    eRdreq = (r && mRdLeft > 0 && o) ? (mSel ? 2'b01 : 2'b10) : 2'b00;
    checkOutput("ready",  ready,     r && !mWait);
    checkOutput("rdreq",  bufRdreq,  eRdreq);
    checkOutput("wrreq",  bufWrreq,  eWrreq);
    checkOutput("data",   bufData,   eData);
    checkOutput("select", bufSelect, mSel);
    checkOutput("valid",  oValid,    eValid);
    checkOutput("done",   bankDone,  eDone);
    checkOutput("err",    err,       eErr);
    if (!r) begin
      mFill = 0; mRdLeft = 0; mWait = 0; mSel = 0;
      eWrreq = '0; eData = '0; eValid = 0; eDone = 0; eErr = 0;
    end else begin
      accept = v && !mWait;
      fire   = (mRdLeft > 0) && o;
      swap   = mWait && (mRdLeft == 0);
`ifdef MFHWT_PPBUF_CTRL_CHK_EN
      if ((eWrreq & full) != 0 || (eRdreq & empty) != 0 ||
          (swap && ((full >> (int'(mSel) * 4)) & 8'h0F) != 8'h0F))
        eErr = 1;
`endif
      eWrreq = accept ? 8'(1 << (int'(mSel) * 4 + mFill / W)) : 8'h00;
      if (accept) eData = data;
      eValid = fire;
      eDone  = fire && (mRdLeft == 1);
      if (accept) begin
        mFill++;
        if (mFill == BANK) begin
          mFill = 0;
          mWait = 1;
        end
      end
      if (fire) mRdLeft--;
      if (swap) begin
        mSel    = !mSel;
        mWait   = 0;
        mRdLeft = W;
      end
    end
  endtask

  initial begin
    rst_n = 0; valid = 0; data = '0; outReady = 0; bufFull = '0; bufEmpty = '0;
    repeat (2) applyStimulus(0, 0, 0, 8'h00, 2'b00);

    // One full bank, then drain it.
    for (int i = 0; i < BANK; i++) applyStimulus(1, 1, 1, 8'h00, 2'b00);
    for (int i = 0; i < W + 60; i++) applyStimulus(1, 0, 1, 8'h00, 2'b00);

    // Two more banks back to back while the previous one drains.
    for (int i = 0; i < 2 * BANK; i++) applyStimulus(1, 1, 1, 8'h00, 2'b00);
    for (int i = 0; i < W + 60; i++) applyStimulus(1, 0, 1, 8'h00, 2'b00);

    // Downstream ready toggling 1010 throughout a burst while writes keep coming.
    for (int i = 0; i < 3 * BANK; i++) applyStimulus(1, 1, (i % 2) == 0, 8'h00, 2'b00);
    for (int i = 0; i < 2 * W + 60; i++) applyStimulus(1, 0, (i % 2) == 0, 8'h00, 2'b00);

    // Reset in the middle of a fill, then restart.
    for (int i = 0; i < 1000; i++) applyStimulus(1, 1, 1, 8'h00, 2'b00);
    applyStimulus(0, 1, 1, 8'h00, 2'b00);
    for (int i = 0; i < BANK + 200; i++) applyStimulus(1, 1, 1, 8'h00, 2'b00);

    // Random traffic with occasional full/empty flag noise.
    for (int i = 0; i < 8000; i++)
      applyStimulus(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 199) == 0) ? 8'($urandom) : 8'h00,
                    ($urandom_range(0, 199) == 0) ? 2'($urandom) : 2'b00);

    // Full flag on row 0 during its writes, sticky until the following reset.
    applyStimulus(0, 0, 1, 8'h00, 2'b00);
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 1, 8'h01, 2'b00);
    for (int i = 0; i < 30; i++) applyStimulus(1, 1, 1, 8'h00, 2'b00);
    applyStimulus(0, 0, 1, 8'h00, 2'b00);

    // Empty flag asserted on the bank being drained.
    for (int i = 0; i < BANK; i++) applyStimulus(1, 1, 1, 8'h00, 2'b00);
    for (int i = 0; i < 50; i++) applyStimulus(1, 0, 1, 8'h0F, 2'b01);
    for (int i = 0; i < W; i++) applyStimulus(1, 0, 1, 8'h00, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
